alarm_ctrl: RTL and testbench

Alarm stage downstream of the clock/timer counter. Consumes the 24-bit BCD time-of-day (HHMMSS), holds a user-settable BCD alarm time (HHMM), and drives a buzzer and LED through a ring/snooze state machine. It also drives four active-low seven-segment digits showing the alarm setting.

---
 rtl/alarm_pkg.sv | 37 +++
 rtl/seg7_dec.sv | 35 +++
 rtl/alarm_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
//   Shared constants and helpers for the alarm stage:
//     - FSM state encoding (IDLE / RING / SNOOZE)
//     - BCD upper limits for the alarm hour and minute fields
//     - seven-segment constants (active-low, bit order {g..a})
//     - bcd_inc(): wrap-around increment of a two-digit BCD field
// ---------------------------------------------------------------------------
package alarm_pkg;

  // FSM state encoding; plain constants keep the encoding visible in waveforms.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RING   = 2'd1;
  localparam logic [1:0] SNOOZE = 2'd2;

  // Largest legal value of each two-digit BCD alarm field.
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Increment a two-digit BCD value, wrapping to 00 after lim.
  // Valid BCD orders the same as binary, so a plain compare finds the limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                         input logic [7:0] lim);
    if (val >= lim) begin
      return 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      return {val[7:4] + 4'd1, 4'd0};
    end else begin
      return {val[7:4], val[3:0] + 4'd1};
    end
  endfunction

endpackage : alarm_pkg

// File: rtl/seg7_dec.sv
// ---------------------------------------------------------------------------
// seg7_dec
//   Single-digit BCD to seven-segment decoder, active-low outputs.
//   Codes 10..15 are not BCD and blank the digit.
//
// Ports
//   digit  in  4  BCD digit
//   seg    out 7  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_dec
  import alarm_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // NOTE: every path through always_comb assigns seg (default arm included);
  // a missing assignment on any path would infer a latch.
  always_comb begin
    unique case (digit)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0011000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : seg7_dec

// File: rtl/alarm_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ctrl
//   Alarm stage behind the time-of-day counter. Holds a BCD alarm time
//   (HHMM), compares it against the incoming BCD time, and runs an
//   IDLE / RING / SNOOZE state machine that drives a buzzer and a blinking
//   LED. The alarm setting is shown on four active-low seven-segment digits.
//
// Parameters
//   TICK_DIV    clk cycles per internal 1 s tick
//   RING_SEC    ticks spent ringing before the alarm gives up
//   SNOOZE_SEC  ticks spent snoozing before ringing again
//   BLINK_DIV   clk cycles per LED toggle while ringing
//
// Ports
//   clk      in   1  system clock, single domain
//   rst      in   1  asynchronous reset, active-low
//   bcdtime  in  24  current time, BCD {h1,h0,m1,m0,s1,s0}
//   en       in   1  alarm armed (level)
//   set      in   1  alarm-set mode (level)
//   swh      in   1  step alarm hour on each tick while set=1
//   swm      in   1  step alarm minute on each tick while set=1
//   snz      in   1  snooze button, active-low, asynchronous to clk
//   buzz     out  1  buzzer drive, high while ringing
//   led      out  1  alarm indicator (blinks ringing, steady snoozing)
//   ahour1, ahour0, amin1, amin0
//            out  7  active-low segments {g..a} of the alarm setting
// ---------------------------------------------------------------------------
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] bcdtime,
  input  logic        en,
  input  logic        set,
  input  logic        swh,
  input  logic        swm,
  input  logic        snz,
  output logic        buzz,
  output logic        led,
  output logic [6:0]  ahour1,
  output logic [6:0]  ahour0,
  output logic [6:0]  amin1,
  output logic [6:0]  amin0
);

  // Counter widths sized to hold the terminal value of each count.
  localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SW      = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] RING_LAST   = SW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   areg;
  logic [23:0]   bt_q;
  logic          match;
  logic          match_q;
  logic          trigger;
  logic          snz_meta;
  logic          snz_sync;
  logic          snz_prev;
  logic          press;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [SW-1:0] sec_cnt;
  logic [BW-1:0] blink_cnt;

  // -------------------------------------------------------------------------
  // 1 s tick: free-running divider, one-cycle pulse on its last count.
  // -------------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Alarm setting. In set mode each tick steps one field; hour wins when
  // both switches are on. Minutes wrap without carrying into the hour.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      areg <= 16'h0000;
    end else if (set && tick) begin
      if (swh) begin
        areg[15:8] <= bcd_inc(areg[15:8], HOUR_MAX);
      end else if (swm) begin
        areg[7:0] <= bcd_inc(areg[7:0], MIN_MAX);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Time match. bcdtime is registered first; match is true for the whole
  // matching second, so the rising edge of match gives a single trigger.
  // -------------------------------------------------------------------------
  assign match   = (bt_q[23:8] == areg) && (bt_q[7:0] == 8'h00);
  assign trigger = match && !match_q && en && !set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bt_q    <= '0;
      match_q <= 1'b0;
    end else begin
      bt_q    <= bcdtime;
      match_q <= match;
    end
  end

  // -------------------------------------------------------------------------
  // Snooze button: two-flop synchronizer, then a registered falling-edge
  // detector. Flops reset to the released (high) level, so a button held
  // down through reset produces at most one press, right after reset, while
  // the FSM is still idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snz_meta <= 1'b1;
      snz_sync <= 1'b1;
      snz_prev <= 1'b1;
      press    <= 1'b0;
    end else begin
      snz_meta <= snz;
      snz_sync <= snz_meta;
      snz_prev <= snz_sync;
      press    <= snz_prev && !snz_sync;
    end
  end

  // -------------------------------------------------------------------------
  // Ring / snooze state machine. Disarming or entering set mode wins over
  // every other event, including a press or timeout in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (!en || set) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) state_next = RING;
        end
        RING: begin
          if (press) begin
            state_next = SNOOZE;
          end else if (tick && (sec_cnt == RING_LAST)) begin
            state_next = IDLE;
          end
        end
        SNOOZE: begin
          if (tick && (sec_cnt == SNOOZE_LAST)) state_next = RING;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // sec_cnt counts ticks spent in the current state; any transition
  // restarts it, even one that lands on a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sec_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        sec_cnt <= '0;
      end else if (tick) begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. led is registered from state_next so it changes on the same
  // edge as the state: lit on RING entry, toggling every BLINK_DIV cycles
  // while ringing, steady in SNOOZE, dark in IDLE.
  // -------------------------------------------------------------------------
  assign buzz = (state == RING);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      led       <= 1'b0;
    end else if (state_next == RING) begin
      if (state != RING) begin
        blink_cnt <= '0;
        led       <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        led       <= !led;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      led       <= (state_next == SNOOZE);
    end
  end

  // -------------------------------------------------------------------------
  // Alarm-setting display, combinational from areg.
  // -------------------------------------------------------------------------
  seg7_dec u_hour1 (.digit(areg[15:12]), .seg(ahour1));
  seg7_dec u_hour0 (.digit(areg[11:8]),  .seg(ahour0));
  seg7_dec u_min1  (.digit(areg[7:4]),   .seg(amin1));
  seg7_dec u_min0  (.digit(areg[3:0]),   .seg(amin0));

endmodule : alarm_ctrl

// File: tb/tb_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_ctrl
//   Directed bench for alarm_ctrl with short timing parameters. Expected
//   output vectors {buzz, led, ahour1, ahour0, amin1, amin0} are queued when
//   stimulus is applied and popped/compared one edge later at the negedge.
//   Tick edges are located with a bench-side cycle counter: the divider
//   starts at 0 out of reset, so ticks act on every 4th posedge after release.
// ---------------------------------------------------------------------------
module tb_alarm_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;
  localparam int BLINK_DIV  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] bcdtime = 24'h000000;
  logic        en  = 1'b0;
  logic        set = 1'b0;
  logic        swh = 1'b0;
  logic        swm = 1'b0;
  logic        snz = 1'b1;
  logic        buzz;
  logic        led;
  logic [6:0]  ahour1;
  logic [6:0]  ahour0;
  logic [6:0]  amin1;
  logic [6:0]  amin0;

  alarm_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bcdtime(bcdtime),
    .en     (en),
    .set    (set),
    .swh    (swh),
    .swm    (swm),
    .snz    (snz),
    .buzz   (buzz),
    .led    (led),
    .ahour1 (ahour1),
    .ahour0 (ahour0),
    .amin1  (amin1),
    .amin0  (amin0)
  );

  always #5 clk = ~clk;

  // Posedges since reset release.
  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    string       tag;
    logic [29:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_h  = 0;
  int   exp_m  = 0;
  int   ring_start = 0;
  int   snooze_start = 0;
  int   target = 0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [29:0] pack(input logic b, input logic l);
    return {b, l, seg(exp_h / 10), seg(exp_h % 10), seg(exp_m / 10), seg(exp_m % 10)};
  endfunction

  // LED phase while ringing: lit for BLINK_DIV cycles, dark for BLINK_DIV.
  function automatic logic ring_led(input int c);
    return (((c - ring_start) / BLINK_DIV) % 2) == 0;
  endfunction

  task automatic expect_out(input string tag, input logic b, input logic l);
    exp_t e;
    e.tag = tag;
    e.val = pack(b, l);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [29:0] obs;
    obs = {buzz, led, ahour1, ahour0, amin1, amin0};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_check(input string tag, input logic b, input logic l);
    expect_out(tag, b, l);
    step();
    check();
  endtask

  task automatic ring_check(input string tag);
    expect_out(tag, 1'b1, ring_led(cyc + 1));
    step();
    check();
  endtask

  // Advance to the negedge just after the next tick edge.
  task automatic to_tick();
    step();
    while (cyc % TICK_DIV != 0) step();
  endtask

  task automatic trigger_ring(input string tag);
    bcdtime = 24'h070059;
    step();
    step();
    bcdtime = 24'h070100;
    step_check({tag, "_edge1"}, 1'b0, 1'b0);
    step_check(tag, 1'b1, 1'b1);
    ring_start = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2 rst = 1'b0;
    expect_out("reset_state", 1'b0, 1'b0);
    #1 check();
    step();
    step();
    rst = 1'b1;
    step_check("post_reset", 1'b0, 1'b0);

    // 1. Set mode: hour steps through 00..23 and wraps
    set = 1'b1;
    swh = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      exp_h = i % 24;
      expect_out($sformatf("hour_step_%0d", i), 1'b0, 1'b0);
      to_tick();
      check();
    end
    // minute steps 00..59 and wraps, hour untouched
    swh = 1'b0;
    swm = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      exp_m = i % 60;
      expect_out($sformatf("min_step_%0d", i), 1'b0, 1'b0);
      to_tick();
      check();
    end
    // program 07:01
    exp_m = 1;
    expect_out("min_to_01", 1'b0, 1'b0);
    to_tick();
    check();
    swm = 1'b0;
    swh = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      exp_h = i;
      expect_out($sformatf("hour_to_%0d", i), 1'b0, 1'b0);
      to_tick();
      check();
    end
    swh = 1'b0;
    set = 1'b0;

    // 2. Trigger and blink
    en = 1'b1;
    bcdtime = 24'h070059;
    step_check("armed_no_match", 1'b0, 1'b0);
    step_check("armed_no_match", 1'b0, 1'b0);
    bcdtime = 24'h070100;
    step_check("trig_edge1", 1'b0, 1'b0);
    step_check("trig_ring", 1'b1, 1'b1);
    ring_start = cyc;
    for (int i = 1; i <= 4; i++) ring_check($sformatf("blink_%0d", i));

    // 3. Auto-off on the 3rd tick after entry, no retrigger on held match
    target = (ring_start / TICK_DIV) * TICK_DIV + RING_SEC * TICK_DIV;
    while (cyc < target - 2) step();
    ring_check("ring_before_timeout");
    step_check("auto_off", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step_check("no_retrigger", 1'b0, 1'b0);

    // 4. Snooze, then re-ring after 2 ticks
    trigger_ring("ring2");
    snz = 1'b0;
    ring_check("snz_k");
    snz = 1'b1;
    ring_check("snz_k1");
    ring_check("snz_k2");
    step_check("snoozed", 1'b0, 1'b1);
    snooze_start = cyc;
    target = (snooze_start / TICK_DIV) * TICK_DIV + SNOOZE_SEC * TICK_DIV;
    while (cyc < target - 2) step();
    step_check("snooze_hold", 1'b0, 1'b1);
    step_check("re_ring", 1'b1, 1'b1);
    ring_start = cyc;

    // 5. Override: en=0 with simultaneous press
    en  = 1'b0;
    snz = 1'b0;
    step_check("force_en", 1'b0, 1'b0);
    en  = 1'b1;
    snz = 1'b1;
    for (int i = 0; i < 4; i++) step_check("force_en_hold", 1'b0, 1'b0);
    // same with set=1
    trigger_ring("ring3");
    set = 1'b1;
    snz = 1'b0;
    step_check("force_set", 1'b0, 1'b0);
    set = 1'b0;
    snz = 1'b1;
    for (int i = 0; i < 4; i++) step_check("force_set_hold", 1'b0, 1'b0);

    // 6. Reset mid-snooze, then snz stuck low through reset
    trigger_ring("ring4");
    snz = 1'b0;
    ring_check("snz4_k");
    snz = 1'b1;
    ring_check("snz4_k1");
    ring_check("snz4_k2");
    step_check("snoozed4", 1'b0, 1'b1);
    bcdtime = 24'h235959;
    en  = 1'b0;
    snz = 1'b0;
    rst = 1'b0;
    exp_h = 0;
    exp_m = 0;
    expect_out("reset_async", 1'b0, 1'b0);
    #1 check();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step_check("post_reset2", 1'b0, 1'b0);
    en = 1'b1;
    step_check("armed_00", 1'b0, 1'b0);
    step_check("armed_00", 1'b0, 1'b0);
    bcdtime = 24'h000000;
    step_check("ring5_edge1", 1'b0, 1'b0);
    step_check("ring5", 1'b1, 1'b1);
    ring_start = cyc;
    for (int i = 1; i <= 3; i++) ring_check($sformatf("stuck_low_%0d", i));
    snz = 1'b1;
    ring_check("snz_release");
    snz = 1'b0;
    ring_check("snz5_k");
    ring_check("snz5_k1");
    ring_check("snz5_k2");
    step_check("snoozed5", 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alarm_ctrl
